// File: rtl/spi_master_apb_rx_if.sv
// APB read-side interface for the SPI master receive path: RX FIFO fed by the
// shift engine, drained by APB reads, plus a status register with sticky overflow.
module spi_master_apb_rx_if #(
    parameter int         DATA_WIDTH = 32,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [3:0] REG_RXFIFO = 4'b1000,
    parameter logic [3:0] REG_RXSTAT = 4'b1001
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [3:0]                    PADDR,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    input  logic                          PWRITE,
    input  logic [DATA_WIDTH-1:0]         PWDATA,
    output logic [DATA_WIDTH-1:0]         PRDATA,
    output logic                          PREADY,
    output logic                          PSLVERR,
    input  logic [DATA_WIDTH-1:0]         spi_data_rx,
    input  logic                          spi_data_rx_valid,
    output logic                          spi_data_rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_elements
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, RESP} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    pslverr_q, pslverr_d;
    logic                    empty, full, push, pop, ovf_set, ovf_clr;
    logic                    hit_fifo, hit_stat, owned;
    logic [DATA_WIDTH-1:0]   stat_word;
    logic                    unused_pwdata;

    assign empty         = (cnt_q == '0);
    assign full          = (cnt_q == CW'(FIFO_DEPTH));
    assign hit_fifo      = (PADDR == REG_RXFIFO);
    assign hit_stat      = (PADDR == REG_RXSTAT);
    assign owned         = PSEL & PENABLE & (hit_fifo | hit_stat);
    // Readiness comes from the pre-pop state, so a full FIFO refuses a push even while popping.
    assign push          = spi_data_rx_valid & ~full;
    assign ovf_set       = spi_data_rx_valid & full;
    assign unused_pwdata = ^PWDATA;

    assign spi_data_rx_ready = ~full;
    assign rx_elements       = cnt_q;
    assign PRDATA            = prdata_q;
    assign PSLVERR           = pslverr_q;

    always_comb begin
        stat_word       = '0;
        stat_word[AW:0] = cnt_q;
        stat_word[16]   = empty;
        stat_word[17]   = full;
        stat_word[18]   = ovf_q;
    end

    always_comb begin
        state_d   = state_q;
        PREADY    = 1'b1;
        prdata_d  = '0;
        pslverr_d = 1'b0;
        pop       = 1'b0;
        ovf_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (owned) begin
                    PREADY  = 1'b0;
                    state_d = RESP;
                    if (hit_fifo) begin
                        if (PWRITE || empty) begin
                            pslverr_d = 1'b1;
                        end else begin
                            prdata_d = mem_q[rptr_q];
                            pop      = 1'b1;
                        end
                    end else if (PWRITE) begin
                        ovf_clr = PWDATA[18];
                    end else begin
                        prdata_d = stat_word;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        // A new overflow in the same cycle as a software clear must not be lost.
        ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) begin
            mem_q[wptr_q] <= spi_data_rx;
        end
    end

endmodule

// File: tb/tb_spi_master_apb_rx_if.sv
// Randomized bench for spi_master_apb_rx_if against a queue-based reference model,
// with directed scenarios pinning the model to hand-computed values.
module tb_spi_master_apb_rx_if;

    localparam int         DW      = 32;
    localparam int         D       = 8;
    localparam logic [3:0] A_FIFO  = 4'b1000;
    localparam logic [3:0] A_STAT  = 4'b1001;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic [3:0]    PADDR = '0;
    logic          PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [DW-1:0] PWDATA = '0;
    logic [DW-1:0] PRDATA;
    logic          PREADY, PSLVERR;
    logic [DW-1:0] spi_data_rx = '0;
    logic          spi_data_rx_valid = 1'b0;
    logic          spi_data_rx_ready;
    logic [3:0]    rx_elements;

    always #5 PCLK = ~PCLK;

    spi_master_apb_rx_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(D),
                           .REG_RXFIFO(A_FIFO), .REG_RXSTAT(A_STAT)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .spi_data_rx(spi_data_rx), .spi_data_rx_valid(spi_data_rx_valid),
        .spi_data_rx_ready(spi_data_rx_ready), .rx_elements(rx_elements)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: FIFO contents as a queue, sticky overflow, pending response.
    logic [DW-1:0] mq[$];
    bit            m_ovf = 0, m_resp = 0, m_err = 0, m_live = 0;
    logic [DW-1:0] m_data = '0;
    bit            rnd_push = 0;

    logic          s_pready, s_pslverr;
    logic [DW-1:0] s_prdata;
    logic [3:0]    s_elems;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit owned_now();
        return PSEL && PENABLE && (PADDR == A_FIFO || PADDR == A_STAT);
    endfunction

    function automatic logic [DW-1:0] stat_val();
        logic [DW-1:0] v;
        v = 32'(mq.size());
        if (mq.size() == 0) v = v + 32'h0001_0000;
        if (mq.size() == D) v = v + 32'h0002_0000;
        if (m_ovf)          v = v + 32'h0004_0000;
        return v;
    endfunction

    function automatic void model_update();
        bit            full, push, set, start, pop, clr, ne;
        logic [DW-1:0] nd;
        if (PRESET) begin
            mq.delete();
            m_ovf = 0; m_resp = 0; m_data = '0; m_err = 0; m_live = 1;
            return;
        end
        if (!m_live) return;
        full  = (mq.size() == D);
        push  = spi_data_rx_valid && !full;
        set   = spi_data_rx_valid && full;
        start = !m_resp && owned_now();
        nd = '0; ne = 0; pop = 0; clr = 0;
        if (start) begin
            if (PADDR == A_FIFO) begin
                if (PWRITE || mq.size() == 0) ne = 1;
                else begin nd = mq[0]; pop = 1; end
            end else if (PWRITE) clr = PWDATA[18];
            else nd = stat_val();
        end
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(spi_data_rx);
        if (set) m_ovf = 1; else if (clr) m_ovf = 0;
        m_resp = start; m_data = nd; m_err = ne;
    endfunction

    // One clock cycle: settle inputs, compare every output to the model, advance both.
    task automatic step();
        if (rnd_push) begin
            spi_data_rx_valid = ($urandom_range(0, 1) == 1);
            spi_data_rx       = $urandom;
        end
        #1;
        s_pready = PREADY; s_prdata = PRDATA; s_pslverr = PSLVERR; s_elems = rx_elements;
        if (m_live) begin
            chk("pready",  {31'b0, PREADY}, m_resp ? 32'd1 : {31'b0, !owned_now()});
            chk("prdata",  PRDATA, m_data);
            chk("pslverr", {31'b0, PSLVERR}, {31'b0, m_err});
            chk("rx_elements", {28'b0, rx_elements}, 32'(mq.size()));
            chk("rx_ready", {31'b0, spi_data_rx_ready}, {31'b0, mq.size() < D});
        end
        model_update();
        @(negedge PCLK);
    endtask

    task automatic apb_xfer(input logic [3:0] addr, input logic wr, input logic [DW-1:0] wd,
                            output logic [DW-1:0] rd, output logic err, output int waits);
        int n;
        PADDR = addr; PWRITE = wr; PWDATA = wd; PSEL = 1'b1; PENABLE = 1'b0;
        step();
        PENABLE = 1'b1;
        n = 0;
        do begin step(); n++; end while (!s_pready && n < 4);
        if (!s_pready) chk("apb_timeout", 32'd0, 32'd1);
        rd = s_prdata; err = s_pslverr; waits = n;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        spi_data_rx_valid = 1'b1; spi_data_rx = d;
        step();
        spi_data_rx_valid = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          err;
        int            w;

        @(negedge PCLK);
        repeat (3) step();
        PRESET = 1'b0;
        step();
        chk("reset_ready", {31'b0, spi_data_rx_ready}, 32'd1);
        chk("reset_elems", {28'b0, rx_elements}, 32'd0);
        apb_xfer(A_STAT, 1'b0, '0, rd, err, w);
        chk("stat_after_reset", rd, 32'h0001_0000);
        chk("stat_after_reset_err", {31'b0, err}, 32'd0);
        chk("owned_wait_cycles", 32'(w), 32'd2);

        spi_data_rx_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            spi_data_rx = 32'hA5A5_0000 + 32'(k);
            step();
        end
        spi_data_rx_valid = 1'b0;
        chk("elems_3", {28'b0, rx_elements}, 32'd3);
        for (int k = 1; k <= 3; k++) begin
            apb_xfer(A_FIFO, 1'b0, '0, rd, err, w);
            chk("fifo_order", rd, 32'hA5A5_0000 + 32'(k));
            chk("elems_after_pop", {28'b0, rx_elements}, 32'(3 - k));
        end

        for (int k = 0; k < 9; k++) begin
            push_word(32'hB000_0000 + 32'(k));
            if (k == 7) chk("ready_low_when_full", {31'b0, spi_data_rx_ready}, 32'd0);
        end
        apb_xfer(A_STAT, 1'b0, '0, rd, err, w);
        chk("stat_full_ovf", rd, 32'h0006_0008);
        apb_xfer(A_STAT, 1'b1, 32'h0004_0000, rd, err, w);
        chk("stat_clear_err", {31'b0, err}, 32'd0);
        apb_xfer(A_STAT, 1'b0, '0, rd, err, w);
        chk("stat_cleared", rd, 32'h0002_0008);

        PADDR = A_FIFO; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        repeat (3) step();
        PSEL = 1'b0;
        chk("no_pop_setup_only", {28'b0, rx_elements}, 32'd8);
        apb_xfer(A_FIFO, 1'b1, 32'h1234_5678, rd, err, w);
        chk("fifo_write_err", {31'b0, err}, 32'd1);
        chk("no_pop_on_write", {28'b0, rx_elements}, 32'd8);
        apb_xfer(4'b0110, 1'b0, '0, rd, err, w);
        chk("foreign_wait_cycles", 32'(w), 32'd1);
        chk("foreign_err", {31'b0, err}, 32'd0);
        chk("no_pop_foreign", {28'b0, rx_elements}, 32'd8);

        for (int k = 0; k < 8; k++) begin
            apb_xfer(A_FIFO, 1'b0, '0, rd, err, w);
            chk("drain_order", rd, 32'hB000_0000 + 32'(k));
        end
        apb_xfer(A_FIFO, 1'b0, '0, rd, err, w);
        chk("empty_read_data", rd, 32'd0);
        chk("empty_read_err", {31'b0, err}, 32'd1);

        for (int k = 0; k < 8; k++) push_word(32'hC0DE_0000 + 32'(k));
        spi_data_rx_valid = 1'b1; spi_data_rx = 32'hDEAD_BEEF;
        PADDR = A_FIFO; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        step();
        PENABLE = 1'b1;
        step();
        spi_data_rx_valid = 1'b0;
        step();
        PSEL = 1'b0; PENABLE = 1'b0;
        chk("full_pop_push_data", s_prdata, 32'hC0DE_0000);
        chk("full_pop_push_count", {28'b0, rx_elements}, 32'd7);
        apb_xfer(A_STAT, 1'b0, '0, rd, err, w);
        chk("full_pop_push_stat", rd, 32'h0004_0007);

        PADDR = A_FIFO; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        step();
        PENABLE = 1'b1;
        step();
        PRESET = 1'b1;
        step();
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        step();
        chk("rst_resp_prdata", s_prdata, 32'd0);
        chk("rst_resp_pslverr", {31'b0, s_pslverr}, 32'd0);
        chk("rst_resp_pready", {31'b0, s_pready}, 32'd1);
        chk("rst_resp_elems", {28'b0, s_elems}, 32'd0);
        chk("rst_resp_ready", {31'b0, spi_data_rx_ready}, 32'd1);

        rnd_push = 1;
        for (int i = 0; i < 400; i++) begin
            logic [3:0] a;
            case ($urandom_range(0, 3))
                0:       a = A_FIFO;
                1:       a = A_STAT;
                2:       a = 4'b0110;
                default: a = 4'($urandom);
            endcase
            apb_xfer(a, ($urandom_range(0, 3) == 0), $urandom, rd, err, w);
            repeat ($urandom_range(0, 2)) step();
            if (i % 97 == 50) begin
                PRESET = 1'b1;
                step();
                PRESET = 1'b0;
            end
        end
        rnd_push = 0;
        spi_data_rx_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
